// File: rtl/fact_arb.sv
// fact_arb: round-robin sequencer that shares one factorial accelerator
// between two requesters. A job walks IDLE -> GO -> WAIT -> RESP -> IDLE.
// The result (or an error after a fact_err or a timeout) goes back to the
// requester that owns the job over a valid/ack handshake.
module fact_arb #(
  parameter int NW      = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic [NW-1:0] n0,
  input  logic [NW-1:0] n1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rsp_valid0,
  output logic          rsp_valid1,
  input  logic          rsp_ack0,
  input  logic          rsp_ack1,
  output logic          rsp_err0,
  output logic          rsp_err1,
  output logic [DW-1:0] rsp_data0,
  output logic [DW-1:0] rsp_data1,
  output logic [NW-1:0] fact_n,
  output logic          fact_go,
  input  logic          fact_done,
  input  logic          fact_err,
  input  logic [DW-1:0] fact_nf,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GO   = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rr;        // owner of the last completed job; the other side wins a tie
  logic            r_owner;     // requester that owns the job in flight
  logic [NW-1:0]   r_n;
  logic [DW-1:0]   r_data;
  logic            r_err;
  logic [CW-1:0]   r_cnt;       // WAIT cycles already spent on this job

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_done_ok;
  logic            w_timeout;
  logic            w_ack;

  // A stale done from the previous job may still be high during the first
  // WAIT cycle, so done only counts once at least one WAIT cycle has passed.
  assign w_done_ok = fact_done && (r_cnt != {CW{1'b0}});
  // r_cnt is zero in the first WAIT cycle, so this fires in the TIMEOUT-th one.
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ack     = r_owner ? rsp_ack1 : rsp_ack0;

  // Round-robin grant decision, only offered while idle and out of reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if ((r_state == S_IDLE) && !rst) begin
      if (req0 && req1) begin
        if (r_rr) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else if (req0) begin
        w_gnt0 = 1'b1;
      end else if (req1) begin
        w_gnt1 = 1'b1;
      end else begin
        w_gnt0 = 1'b0;
      end
    end else begin
      w_gnt0 = 1'b0;
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_state_nxt = S_GO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GO: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done_ok || w_timeout) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP: begin
        if (w_ack) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; a reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Job datapath: operand/owner latch, timeout counter, result capture, rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr    <= 1'b1;
      r_owner <= 1'b0;
      r_n     <= {NW{1'b0}};
      r_data  <= {DW{1'b0}};
      r_err   <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0) begin
            r_n     <= n0;
            r_owner <= 1'b0;
          end else if (w_gnt1) begin
            r_n     <= n1;
            r_owner <= 1'b1;
          end
        end
        S_GO: begin
          r_cnt <= {CW{1'b0}};
        end
        S_WAIT: begin
          if (r_cnt != CW'(TIMEOUT)) begin
            r_cnt <= r_cnt + CW'(1);
          end
          // done takes priority over a timeout landing in the same cycle
          if (w_done_ok) begin
            r_data <= fact_err ? {DW{1'b0}} : fact_nf;
            r_err  <= fact_err;
          end else if (w_timeout) begin
            r_data <= {DW{1'b0}};
            r_err  <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_ack) begin
            r_rr <= r_owner;
          end
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Outputs are decoded from the state and owner registers; the non-owner
  // side of the response port stays at zero.
  assign gnt0       = w_gnt0;
  assign gnt1       = w_gnt1;
  assign fact_go    = (r_state == S_GO);
  assign fact_n     = r_n;
  assign busy       = (r_state != S_IDLE);
  assign rsp_valid0 = (r_state == S_RESP) && !r_owner;
  assign rsp_valid1 = (r_state == S_RESP) &&  r_owner;
  assign rsp_err0   = rsp_valid0 && r_err;
  assign rsp_err1   = rsp_valid1 && r_err;
  assign rsp_data0  = rsp_valid0 ? r_data : {DW{1'b0}};
  assign rsp_data1  = rsp_valid1 ? r_data : {DW{1'b0}};

endmodule
